// File: rtl/matrix_pkg.sv
// Shared dimensions, FSM state type and frame row-slice helper for the LED matrix scan path.
package matrix_pkg;

    localparam int unsigned ROWS    = 8;
    localparam int unsigned COLS    = 16;
    localparam int unsigned FRAME_W = ROWS * COLS;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, SHOW} state_t;

    // Row 0 occupies the top COLS bits of the frame; bit COLS-1 is the leftmost column.
    function automatic logic [COLS-1:0] row_bits(input logic [FRAME_W-1:0] frame,
                                                 input int unsigned r);
        logic [FRAME_W-1:0] sh;
        sh = frame >> (COLS * (ROWS - 1 - r));
        return sh[COLS-1:0];
    endfunction

endpackage

// File: rtl/col_serializer.sv
// Shifts one matrix row out MSB first: each bit is held for 2*SHIFT_DIV cycles, with the
// column clock low for the first half and high for the second; done pulses on the last cycle.
module col_serializer
    import matrix_pkg::*;
#(
    parameter int unsigned SHIFT_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [COLS-1:0] data,
    output logic            ser_data,
    output logic            ser_clk,
    output logic            done
);

    localparam int unsigned PhW  = $clog2(2 * SHIFT_DIV);
    localparam int unsigned BitW = $clog2(COLS);

    logic [COLS-1:0] shreg_q;
    logic [BitW-1:0] bit_q;
    logic [PhW-1:0]  phase_q;
    logic            busy_q;
    logic            last_phase;

    assign last_phase = (phase_q == PhW'(2 * SHIFT_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
        end else if (load) begin
            shreg_q <= data;
            bit_q   <= BitW'(COLS - 1);
            phase_q <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (last_phase) begin
                phase_q <= '0;
                shreg_q <= shreg_q << 1;
                if (bit_q == '0) begin
                    busy_q <= 1'b0;
                end else begin
                    bit_q <= bit_q - 1'b1;
                end
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    assign ser_data = busy_q & shreg_q[COLS-1];
    assign ser_clk  = busy_q & (phase_q >= PhW'(SHIFT_DIV));
    assign done     = busy_q & last_phase & (bit_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller: double-buffers frames, swaps only at row 0, shifts/latches/shows each row.
// Optional MATRIX_DIM_EN adds a brightness input that shortens the lit part of each SHOW phase.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned SHIFT_DIV = 4,
    parameter int unsigned ROW_HOLD  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frameData,
    input  logic               frameValid,
`ifdef MATRIX_DIM_EN
    input  logic [3:0]         brightness,
`endif
    output logic               frameReady,
    output logic               serData,
    output logic               serClk,
    output logic               serLatch,
    output logic [ROWS-1:0]    rowEn,
    output logic               frameTick
);

    localparam int unsigned RowW   = $clog2(ROWS);
    localparam int unsigned CntMax = (ROW_HOLD > SHIFT_DIV) ? ROW_HOLD : SHIFT_DIV;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    state_t             state_q, state_d;
    logic [RowW-1:0]    row_q, row_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0] pending_q, active_q;
    logic               pending_full_q;
    logic               accept, swap, ser_load, ser_done, lit_on;
    logic [COLS-1:0]    load_bits;

    assign accept   = frameValid & ~pending_full_q;
    assign swap     = (state_q == LOAD) && (row_q == '0) && pending_full_q;
    assign ser_load = (state_q == LOAD);
    // The swap lands at the end of LOAD, so the row-0 load must take the pending copy directly.
    assign load_bits = swap ? row_bits(pending_q, 0) : row_bits(active_q, 32'(row_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            if (swap) begin
                active_q       <= pending_q;
                pending_full_q <= 1'b0;
            end
            if (accept) begin
                pending_q      <= frameData;
                pending_full_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE:  if (accept) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: if (ser_done) state_d = LATCH;
            LATCH: begin
                if (cnt_q == CntW'(SHIFT_DIV - 1)) state_d = SHOW;
                else cnt_d = cnt_q + 1'b1;
            end
            SHOW: begin
                if (cnt_q == CntW'(ROW_HOLD - 1)) begin
                    state_d = LOAD;
                    row_d   = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MATRIX_DIM_EN
    localparam int unsigned LitW = $clog2(ROW_HOLD + 1);

    logic [LitW-1:0] lit_q;
    int unsigned     lit_calc;

    always_comb begin
        lit_calc = ((32'(brightness) + 32'd1) * ROW_HOLD) >> 4;
        if (lit_calc == 0) lit_calc = 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_q <= '0;
        end else if (state_q == LOAD) begin
            lit_q <= LitW'(lit_calc);
        end
    end

    assign lit_on = (32'(cnt_q) < 32'(lit_q));
`else
    assign lit_on = 1'b1;
`endif

    col_serializer #(
        .SHIFT_DIV(SHIFT_DIV)
    ) u_col_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ser_load),
        .data    (load_bits),
        .ser_data(serData),
        .ser_clk (serClk),
        .done    (ser_done)
    );

    assign frameReady = ~pending_full_q;
    assign frameTick  = (state_q == LOAD) && (row_q == '0);
    assign serLatch   = (state_q == LATCH);
    assign rowEn      = ((state_q == SHOW) && lit_on) ? (ROWS'(1) << row_q) : '0;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl against a cycle-position model of the scan timeline.
module tb_matrix_scan_ctrl;
    import matrix_pkg::*;

    localparam int unsigned SD     = 1;
    localparam int unsigned RH     = 4;
    localparam int unsigned SHLEN  = 2 * COLS * SD;
    localparam int unsigned PERIOD = 1 + SHLEN + SD + RH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] frameData = '0;
    logic         frameValid = 1'b0;
    logic         frameReady, serData, serClk, serLatch, frameTick;
    logic [7:0]   rowEn;
`ifdef MATRIX_DIM_EN
    logic [3:0]   brightness = 4'hF;
`endif

    matrix_scan_ctrl #(
        .SHIFT_DIV(SD),
        .ROW_HOLD (RH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frameData (frameData),
        .frameValid(frameValid),
`ifdef MATRIX_DIM_EN
        .brightness(brightness),
`endif
        .frameReady(frameReady),
        .serData   (serData),
        .serClk    (serClk),
        .serLatch  (serLatch),
        .rowEn     (rowEn),
        .frameTick (frameTick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position within the row period plus row index and the two frame buffers.
    bit           m_run, m_pfull;
    int           m_pos, m_row, m_lit;
    logic [127:0] m_active, m_pending;
    logic [15:0]  m_cur;

    logic [15:0]  cap;
    logic [15:0]  words [8];
    bit           prev_sc, prev_lat;
    int           cyc = 0;
    int           last_tick = -1;

    typedef struct {
        logic [127:0] frame;
        int           row;
        logic [15:0]  word;
    } vec_t;

    function automatic logic [15:0] slice(input logic [127:0] f, input int r);
        return f[127-16*r -: 16];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pfull = 0; m_pos = 0; m_row = 0; m_lit = RH;
        m_active = '0; m_pending = '0; m_cur = '0;
        cap = '0; prev_sc = 0; prev_lat = 0; last_tick = -1;
        for (int i = 0; i < 8; i++) words[i] = '0;
    endtask

    task automatic check_outputs();
        logic [12:0] exp, got;
        logic e_tick, e_sd, e_sc, e_lat;
        logic [7:0] e_row;
        int k;
        e_tick = 0; e_sd = 0; e_sc = 0; e_lat = 0; e_row = '0;
        if (m_run) begin
            if (m_pos == 0) begin
                e_tick = (m_row == 0);
            end else if (m_pos <= SHLEN) begin
                k    = m_pos - 1;
                e_sd = m_cur[COLS-1-k/(2*SD)];
                e_sc = (k % (2 * SD)) >= SD;
            end else if (m_pos <= SHLEN + SD) begin
                e_lat = 1;
            end else if (m_pos - (1 + SHLEN + SD) < m_lit) begin
                e_row = 8'(1 << m_row);
            end
        end
        exp = {~m_pfull, e_tick, e_sd, e_sc, e_lat, e_row};
        got = {frameReady, frameTick, serData, serClk, serLatch, rowEn};
        check("cycle_outputs", 128'(got), 128'(exp));
        if (frameTick) begin
            if (last_tick >= 0) check("tick_period", 128'(cyc - last_tick), 128'(8 * PERIOD));
            last_tick = cyc;
        end
        if (serClk && !prev_sc) cap = {cap[14:0], serData};
        if (serLatch && !prev_lat) words[m_row] = cap;
        prev_sc  = serClk;
        prev_lat = serLatch;
    endtask

    task automatic model_edge(input logic v, input logic [127:0] d, input int b);
        bit acc;
        acc = v && !m_pfull;
        if (!m_run) begin
            if (acc) begin m_run = 1; m_pos = 0; m_row = 0; end
        end else begin
            if (m_pos == 0) begin
                if (m_row == 0 && m_pfull) begin m_active = m_pending; m_pfull = 0; end
                m_cur = slice(m_active, m_row);
`ifdef MATRIX_DIM_EN
                m_lit = ((b + 1) * RH) / 16;
                if (m_lit < 1) m_lit = 1;
`else
                m_lit = RH + 0 * b;
`endif
            end
            m_pos++;
            if (m_pos == PERIOD) begin m_pos = 0; m_row = (m_row + 1) % ROWS; end
        end
        if (acc) begin m_pending = d; m_pfull = 1; end
    endtask

    task automatic step(input logic v, input logic [127:0] d);
        int b;
        @(negedge clk);
        cyc++;
        check_outputs();
        frameValid = v;
        frameData  = d;
        b = 15;
`ifdef MATRIX_DIM_EN
        brightness = 4'($urandom_range(0, 15));
        b = int'(brightness);
`endif
        model_edge(v, d, b);
    endtask

    task automatic do_reset();
        rst_n = 0; frameValid = 0; frameData = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 128'({frameReady, frameTick, serData, serClk, serLatch, rowEn}),
              128'({1'b1, 12'h000}));
        rst_n = 1;
    endtask

    vec_t         vt [6];
    logic [127:0] fa, fb, fc;
    bit           found;

    initial begin
        fa = {16'hA5F0, 112'h0};
        fb = {16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        fc = {16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000, 16'hCAFE, 16'h5555, 16'hBEEF};
        vt[0] = '{fa, 0, 16'hA5F0};
        vt[1] = '{fa, 1, 16'h0000};
        vt[2] = '{fc, 0, 16'h0001};
        vt[3] = '{fc, 3, 16'h1234};
        vt[4] = '{fc, 5, 16'hCAFE};
        vt[5] = '{fc, 7, 16'hBEEF};

        // Idle after reset: nothing offered, nothing scanned.
        do_reset();
        repeat (60) step(0, rand128());

        // Table: load one frame, run a full frame, compare the word shifted out for a row.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            step(1, vt[i].frame);
            repeat (305) step(0, rand128());
            check("row_word", 128'(words[vt[i].row]), 128'(vt[i].word));
        end

        // Frame B offered mid-frame A: A finishes unchanged, B starts at the next row 0.
        do_reset();
        step(1, fa);
        repeat (99) step(0, '0);
        step(1, fb);
        step(0, '0);
        check("ready_low_after_accept", 128'(frameReady), 128'(0));
        repeat (200) step(0, '0);
        check("a_row1_kept", 128'(words[1]), 128'(slice(fa, 1)));
        check("a_row7_kept", 128'(words[7]), 128'(slice(fa, 7)));
        repeat (45) step(0, '0);
        check("b_row0_after_swap", 128'(words[0]), 128'(slice(fb, 0)));
        check("b_ready_back", 128'(frameReady), 128'(1));

        // Reset during SHIFT of row 3.
        do_reset();
        step(1, fc);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_run && m_row == 3 && m_pos > 5 && m_pos < 30) found = 1;
            else step(0, '0);
        end
        check("reach_row3_shift", 128'(found), 128'(1));
        rst_n = 0;
        #1;
        check("async_reset_outputs",
              128'({frameReady, frameTick, serData, serClk, serLatch, rowEn}),
              128'({1'b1, 12'h000}));
        frameValid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (60) step(0, rand128());
        step(1, fb);
        repeat (80) step(0, rand128());

        // Random offers against the model, including back-pressure while pending is full.
        do_reset();
        for (int i = 0; i < 3000; i++) step(($urandom_range(0, 99) < 4), rand128());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
